// File: rtl/freq_div_pkg.sv
// Shared definitions for the clock-divider family and the divided-clock period meter.
package freq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/div_clk_period_meter_if.sv
// Control/result bundle of the period meter; master drives the stimulus, slave is the meter.
interface div_clk_period_meter_if #(
  parameter int WIDTH = freq_div_pkg::DEF_WIDTH
);
  logic             enable;
  logic             sig_in;
  logic             edge_tick;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             timeout;

  modport master (output enable, sig_in, input edge_tick, period, period_valid, timeout);
  modport slave  (input enable, sig_in, output edge_tick, period, period_valid, timeout);
endinterface

// File: rtl/sync_rise_det.sv
// Synchronizes an asynchronous level and flags its rising edges in the clk domain.
module sync_rise_det
  import freq_div_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_ah_in,
  input  logic sig_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_sync;
  logic                   sig_prev;

  assign sig_sync = sync_q[SYNC_STAGES-1];

  // edge_det is registered so the parent never sees a path straight off the synchronizer
  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      sync_q   <= '0;
      sig_prev <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_prev <= sig_sync;
      edge_det <= sig_sync & ~sig_prev;
    end
  end

endmodule

// File: rtl/div_clk_period_meter.sv
// Measures the period of a divided clock, sampled as data, in clk cycles with timeout on saturation.
module div_clk_period_meter
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic                   clk,
  input logic                   reset_ah_in,
  div_clk_period_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             edge_det;
  meter_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             tick_q, tick_d;
  logic             to_q, to_d;

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset_ah_in (reset_ah_in),
    .sig_in      (bus.sig_in),
    .edge_det    (edge_det)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    tick_d   = 1'b0;
    to_d     = to_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      to_d    = 1'b0;
    end else begin
      tick_d = edge_det && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (edge_det) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
            to_d    = 1'b0;
          end
        end
        ST_MEASURE: begin
          // an edge landing on the saturated count still reports a valid period
          if (edge_det) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            to_d    = 1'b1;
            state_d = ST_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_ah_in) begin
    if (reset_ah_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      tick_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      tick_q   <= tick_d;
      to_q     <= to_d;
    end
  end

  assign bus.edge_tick    = tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.timeout      = to_q;

endmodule

// File: tb/tb_div_clk_period_meter.sv
// Two meters (narrow counter / deep synchronizer) checked every cycle against a timestamp model.
module tb_div_clk_period_meter;
  import freq_div_pkg::*;

  localparam int WA = 4;
  localparam int SA = 2;
  localparam int WB = 16;
  localparam int SB = 3;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic en;

  always #5 clk = ~clk;

  div_clk_period_meter_if #(.WIDTH(WA)) bus_a ();
  div_clk_period_meter_if #(.WIDTH(WB)) bus_b ();

  assign bus_a.sig_in = sig;
  assign bus_a.enable = en;
  assign bus_b.sig_in = sig;
  assign bus_b.enable = en;

  div_clk_period_meter #(.WIDTH(WA), .SYNC_STAGES(SA)) dut_a (
    .clk(clk), .reset_ah_in(rst), .bus(bus_a.slave));
  div_clk_period_meter #(.WIDTH(WB), .SYNC_STAGES(SB)) dut_b (
    .clk(clk), .reset_ah_in(rst), .bus(bus_b.slave));

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // reference: sig_in samples since reset, plus per-meter timestamps of the last edge
  bit hist[$];
  int m_mode[2];      // 0 off, 1 waiting for first edge, 2 measuring
  int m_last[2];
  int m_period[2];
  bit m_pv[2], m_tick[2], m_to[2];

  function automatic bit samp(int j);
    return (j >= 0 && j < hist.size()) ? hist[j] : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_last[d] = 0; m_period[d] = 0;
      m_pv[d] = 0; m_tick[d] = 0; m_to[d] = 0;
    end
  endtask

  task automatic model_step(input bit en_v);
    int  stg[2];
    int  wid[2];
    int  maxp;
    bit  e;
    stg = '{SA, SB};
    wid = '{WA, WB};
    for (int d = 0; d < 2; d++) begin
      // a rising sample at k becomes visible to the meter at cycle k+stages+1
      e = samp(cyc - stg[d] - 1) & ~samp(cyc - stg[d] - 2);
      maxp = (1 << wid[d]) - 1;
      m_pv[d] = 0;
      m_tick[d] = 0;
      if (!en_v) begin
        m_mode[d] = 0;
        m_to[d] = 0;
      end else begin
        m_tick[d] = e && (m_mode[d] != 0);
        if (m_mode[d] == 0) m_mode[d] = 1;
        else if (m_mode[d] == 1) begin
          if (e) begin m_mode[d] = 2; m_last[d] = cyc; m_to[d] = 0; end
        end else begin
          if (e) begin
            m_period[d] = cyc - m_last[d];
            m_pv[d] = 1;
            m_last[d] = cyc;
          end else if (cyc - m_last[d] == maxp) begin
            m_to[d] = 1;
            m_mode[d] = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  task automatic check_outputs();
    chk("a_edge_tick", bus_a.edge_tick,    m_tick[0]);
    chk("a_period_valid", bus_a.period_valid, m_pv[0]);
    chk("a_period",    bus_a.period,       m_period[0]);
    chk("a_timeout",   bus_a.timeout,      m_to[0]);
    chk("b_edge_tick", bus_b.edge_tick,    m_tick[1]);
    chk("b_period_valid", bus_b.period_valid, m_pv[1]);
    chk("b_period",    bus_b.period,       m_period[1]);
    chk("b_timeout",   bus_b.timeout,      m_to[1]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_tick"},   bus_a.edge_tick,    0);
    chk({tag, "_a_pv"},     bus_a.period_valid, 0);
    chk({tag, "_a_period"}, bus_a.period,       0);
    chk({tag, "_a_to"},     bus_a.timeout,      0);
    chk({tag, "_b_tick"},   bus_b.edge_tick,    0);
    chk({tag, "_b_pv"},     bus_b.period_valid, 0);
    chk({tag, "_b_period"}, bus_b.period,       0);
    chk({tag, "_b_to"},     bus_b.timeout,      0);
  endtask

  task automatic tick(input bit s_v, input bit en_v);
    @(negedge clk);
    sig = s_v;
    en  = en_v;
    @(posedge clk);
    hist.push_back(s_v);
    cyc = hist.size() - 1;
    model_step(en_v);
    #1 check_outputs();
  endtask

  int p, h, len, lat;

  initial begin
    rst = 1'b1; sig = 1'b0; en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // nominal divide-by-4
    for (int i = 0; i < 48; i++) tick(bit'((i >> 1) & 1), 1'b1);
    // minimum period: toggle every cycle
    for (int i = 0; i < 24; i++) tick(bit'(i & 1), 1'b1);
    // long low: narrow meter times out, then recovers
    repeat (30) tick(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) tick((i % 6) < 3, 1'b1);
    // edges exactly at the narrow counter's saturation point
    for (int i = 0; i < 75; i++) tick((i % 15) == 0, 1'b1);

    // randomized square waves, some slower than the narrow counter can hold
    for (int blk = 0; blk < 10; blk++) begin
      p   = $urandom_range(2, 20);
      h   = (p / 2 > 0) ? p / 2 : 1;
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) tick((i % p) < h, 1'b1);
    end
    // random noise with occasional enable drops
    for (int i = 0; i < 150; i++)
      tick(bit'($urandom_range(0, 1)), $urandom_range(0, 19) != 0);

    // enable dropped mid-period, then restored
    for (int i = 0; i < 20; i++) tick(bit'((i >> 1) & 1), 1'b1);
    for (int i = 0; i < 5; i++)  tick(bit'((i >> 1) & 1), 1'b0);
    for (int i = 0; i < 30; i++) tick(bit'((i >> 1) & 1), 1'b1);

    // asynchronous reset in the middle of a period
    for (int i = 0; i < 11; i++) tick(bit'((i >> 1) & 1), 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 30; i++) tick(bit'((i >> 1) & 1), 1'b1);

    // latency of the 3-stage meter from the sampling edge to edge_tick
    repeat (12) tick(1'b0, 1'b1);
    lat = -1;
    for (int j = 0; j < 10; j++) begin
      tick(1'b1, 1'b1);
      if (bus_b.edge_tick === 1'b1) begin
        lat = j;
        break;
      end
    end
    chk("latency_b", lat, 4);
    repeat (8) tick(1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
